// File: rtl/pam4_pkg.sv
// Shared definitions for the PAM-4 receive path: the Gray level map, checker
// state encoding and PRBS31 tap positions.
package pam4_pkg;

  // Gray symbols from the lowest to the highest nominal level.
  localparam logic [1:0] GrayLvl0 = 2'b00;
  localparam logic [1:0] GrayLvl1 = 2'b01;
  localparam logic [1:0] GrayLvl2 = 2'b11;
  localparam logic [1:0] GrayLvl3 = 2'b10;

  typedef enum logic [1:0] {
    StSeed   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } state_e;

  // PRBS31: x^31 + x^28 + 1.
  localparam int unsigned PrbsLen = 31;
  localparam int unsigned PrbsTap = 28;

  // Symbols needed to fill the history register (two bits per symbol).
  localparam int unsigned SeedSymbols = (PrbsLen + 1) / 2;

endpackage

// File: rtl/pam4_slicer.sv
// Registered PAM-4 slicer: maps a two's-complement voltage onto a Gray symbol
// using thresholds -S, 0, +S. Output appears one cycle after a valid input and
// holds while the input is not valid.
//   clk, rst         : clock, synchronous active-high reset
//   sample_i         : DFE output voltage (signed)
//   sample_valid_i   : qualifies sample_i
//   symbol_o         : sliced Gray symbol
//   symbol_valid_o   : registered copy of sample_valid_i
module pam4_slicer #(
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned SYMBOL_SEPERATION = 56
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] sample_i,
  input  logic                         sample_valid_i,
  output logic [1:0]                   symbol_o,
  output logic                         symbol_valid_o
);
  import pam4_pkg::*;

  // One extra bit so that +/-S are representable regardless of resolution.
  localparam logic signed [SIGNAL_RESOLUTION:0] SepPos =
      (SIGNAL_RESOLUTION + 1)'(SYMBOL_SEPERATION);
  localparam logic signed [SIGNAL_RESOLUTION:0] SepNeg = -SepPos;

  logic signed [SIGNAL_RESOLUTION:0] v_ext;
  logic [1:0] sliced;
  logic [1:0] symbol_q, symbol_d;
  logic       valid_q;

  assign v_ext = {sample_i[SIGNAL_RESOLUTION-1], sample_i};

  always_comb begin
    if (v_ext < SepNeg) begin
      sliced = GrayLvl0;
    end else if (v_ext[SIGNAL_RESOLUTION]) begin
      sliced = GrayLvl1;
    end else if (v_ext < SepPos) begin
      sliced = GrayLvl2;
    end else begin
      sliced = GrayLvl3;
    end
  end

  always_comb begin
    symbol_d = sample_valid_i ? sliced : symbol_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      symbol_q <= 2'b00;
      valid_q  <= 1'b0;
    end else begin
      symbol_q <= symbol_d;
      valid_q  <= sample_valid_i;
    end
  end

  assign symbol_o       = symbol_q;
  assign symbol_valid_o = valid_q;

endmodule

// File: rtl/pam4_rx_checker.sv
// PAM-4 receive checker: slices DFE voltages, unpacks Gray symbols to bits and
// runs a PRBS31 checker with a SEED/HUNT/LOCKED lock machine for BER counting.
//   clk, rst          : clock, synchronous active-high reset
//   signal_in(_valid) : DFE output voltage and qualifier
//   clear_counters    : zeroes bit_count/err_count, lock unaffected
//   symbol_out(_valid): registered sliced symbol
//   locked            : high in LOCKED
//   lock_lost         : one-cycle pulse on LOCKED -> SEED
//   bit_count         : bits checked while locked (saturating)
//   err_count         : bit errors while locked (saturating)
module pam4_rx_checker #(
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned SYMBOL_SEPERATION = 56,
  parameter int unsigned LOCK_BITS         = 64,
  parameter int unsigned WINDOW_BITS       = 1024,
  parameter int unsigned ERR_THRESH        = 64,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                         signal_in_valid,
  input  logic                         clear_counters,
  output logic [1:0]                   symbol_out,
  output logic                         symbol_out_valid,
  output logic                         locked,
  output logic                         lock_lost,
  output logic [CNT_WIDTH-1:0]         bit_count,
  output logic [CNT_WIDTH-1:0]         err_count
);
  import pam4_pkg::*;

  localparam int unsigned MatchW = $clog2(LOCK_BITS) + 1;
  localparam int unsigned WinW   = $clog2(WINDOW_BITS) + 1;
  localparam int unsigned ErrW   = $clog2(ERR_THRESH + 3) + 1;
  localparam int unsigned SeedW  = $clog2(SeedSymbols);
  localparam logic [SeedW-1:0] SeedLast = SeedW'(SeedSymbols - 1);

  logic [1:0] sym;
  logic       sym_valid;

  pam4_slicer #(
    .SIGNAL_RESOLUTION(SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION(SYMBOL_SEPERATION)
  ) u_slicer (
    .clk           (clk),
    .rst           (rst),
    .sample_i      (signal_in),
    .sample_valid_i(signal_in_valid),
    .symbol_o      (sym),
    .symbol_valid_o(sym_valid)
  );

  state_e                 state_q, state_d;
  logic [PrbsLen-1:0]     s_q, s_d;
  logic [SeedW-1:0]       seed_cnt_q, seed_cnt_d;
  logic [MatchW-1:0]      match_cnt_q, match_cnt_d;
  logic [WinW-1:0]        win_bits_q, win_bits_d;
  logic [ErrW-1:0]        win_err_q, win_err_d;
  logic [CNT_WIDTH-1:0]   bit_count_q, bit_count_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic                   lock_lost_q, lock_lost_d;

  // Predictions for the earlier (symbol[1]) and later (symbol[0]) bit.
  logic              p1, p0, err1, err0;
  logic [1:0]        n_err, bit_inc, err_inc;
  logic [MatchW-1:0] match_next;
  logic [WinW-1:0]   win_bits_next;
  logic [ErrW-1:0]   win_err_sum;
  logic              hunt_done, win_full, too_many;

  assign p1   = s_q[PrbsLen-1] ^ s_q[PrbsTap-1];
  assign p0   = s_q[PrbsLen-2] ^ s_q[PrbsTap-2];
  assign err1 = sym[1] ^ p1;
  assign err0 = sym[0] ^ p0;
  assign n_err = {1'b0, err1} + {1'b0, err0};

  assign match_next    = match_cnt_q + MatchW'(2);
  assign hunt_done     = match_next >= MatchW'(LOCK_BITS);
  assign win_bits_next = win_bits_q + WinW'(2);
  assign win_full      = win_bits_next >= WinW'(WINDOW_BITS);
  assign win_err_sum   = win_err_q + ErrW'(n_err);
  assign too_many      = win_err_sum > ErrW'(ERR_THRESH);

  function automatic logic [CNT_WIDTH-1:0] sat_add(logic [CNT_WIDTH-1:0] a, logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH - 1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSeed;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (sym_valid) begin
      unique case (state_q)
        StSeed:   if (seed_cnt_q == SeedLast) state_d = StHunt;
        StHunt:   if (!(err1 || err0) && hunt_done) state_d = StLocked;
        StLocked: if (too_many) state_d = StSeed;
        default:  state_d = StSeed;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    locked    = (state_q == StLocked);
    lock_lost = lock_lost_q;
  end

  // Checker datapath and counters.
  always_comb begin
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_err_d   = win_err_q;
    bit_inc     = 2'd0;
    err_inc     = 2'd0;
    lock_lost_d = 1'b0;
    if (sym_valid) begin
      unique case (state_q)
        StSeed: begin
          s_d        = {s_q[PrbsLen-3:0], sym};
          seed_cnt_d = (seed_cnt_q == SeedLast) ? '0 : seed_cnt_q + SeedW'(1);
        end
        StHunt: begin
          s_d = {s_q[PrbsLen-3:0], sym};
          if (err1 || err0 || hunt_done) begin
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_next;
          end
        end
        StLocked: begin
          // Free-run the generator so one line error is counted once.
          s_d     = {s_q[PrbsLen-3:0], p1, p0};
          bit_inc = 2'd2;
          err_inc = n_err;
          if (too_many) begin
            lock_lost_d = 1'b1;
            match_cnt_d = '0;
            win_bits_d  = '0;
            win_err_d   = '0;
          end else if (win_full) begin
            win_bits_d = '0;
            win_err_d  = '0;
          end else begin
            win_bits_d = win_bits_next;
            win_err_d  = win_err_sum;
          end
        end
        default: ;
      endcase
    end
    bit_count_d = clear_counters ? '0 : sat_add(bit_count_q, bit_inc);
    err_count_d = clear_counters ? '0 : sat_add(err_count_q, err_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_err_q   <= win_err_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign symbol_out       = sym;
  assign symbol_out_valid = sym_valid;
  assign bit_count        = bit_count_q;
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_pam4_rx_checker.sv
// Directed bench for pam4_rx_checker: reset, slicer thresholds, lock on a clean
// PRBS31 stream, single and coincident-clear errors, mid-run reset, gapped
// valids and loss of lock under a constant input.
module tb_pam4_rx_checker;

  localparam int Sep = 56;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  signal_in;
  logic        signal_in_valid;
  logic        clear_counters;
  logic [1:0]  symbol_out;
  logic        symbol_out_valid;
  logic        locked;
  logic        lock_lost;
  logic [31:0] bit_count;
  logic [31:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int nsent    = 0;

  logic [30:0] gen_s = 31'h2A5A1234;

  always #5 clk = ~clk;

  pam4_rx_checker dut (
    .clk             (clk),
    .rst             (rst),
    .signal_in       (signal_in),
    .signal_in_valid (signal_in_valid),
    .clear_counters  (clear_counters),
    .symbol_out      (symbol_out),
    .symbol_out_valid(symbol_out_valid),
    .locked          (locked),
    .lock_lost       (lock_lost),
    .bit_count       (bit_count),
    .err_count       (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference PRBS31 source; the earlier bit lands in sym[1].
  task automatic gen_sym(output logic [1:0] sym);
    logic nb;
    for (int b = 1; b >= 0; b--) begin
      nb     = gen_s[30] ^ gen_s[27];
      gen_s  = {gen_s[29:0], nb};
      sym[b] = nb;
    end
  endtask

  // Gray symbol to nominal PAM-4 voltage.
  function automatic logic [7:0] level(input logic [1:0] sym);
    int v;
    case (sym)
      2'b00:   v = -3 * Sep / 2;
      2'b01:   v = -Sep / 2;
      2'b11:   v = Sep / 2;
      default: v = 3 * Sep / 2;
    endcase
    return 8'(v);
  endfunction

  task automatic send_val(input logic [7:0] v);
    signal_in       = v;
    signal_in_valid = 1'b1;
    step();
    nsent++;
  endtask

  task automatic send_clean();
    logic [1:0] sym;
    gen_sym(sym);
    send_val(level(sym));
  endtask

  task automatic idle(input int n);
    signal_in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Sends clean symbols until one is 11, which goes out as 84 (slices to 10).
  task automatic send_one_lsb_error(input string tag);
    logic [1:0] sym;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      gen_sym(sym);
      if (sym == 2'b11) begin
        send_val(level(2'b10));
        found = 1'b1;
      end else begin
        send_val(level(sym));
      end
    end
    check(tag, found, 1'b1);
  endtask

  int          slice_v[6] = '{-57, -56, -1, 0, 55, 56};
  logic [1:0]  slice_e[6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

  initial begin
    logic [1:0] sym;
    int         cum;
    int         e;
    logic       hit;

    rst             = 1'b1;
    clear_counters  = 1'b0;
    signal_in       = '0;
    signal_in_valid = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      signal_in       = 8'($urandom);
      signal_in_valid = 1'($urandom);
      step();
    end
    check("rst_symbol", 32'(symbol_out), 32'd0);
    check("rst_valid", 32'(symbol_out_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_bit_count", bit_count, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    rst             = 1'b0;
    signal_in_valid = 1'b0;
    signal_in       = 8'($urandom);
    step();
    check("post_rst_valid", 32'(symbol_out_valid), 32'd0);

    // Slicer thresholds.
    for (int i = 0; i < 6; i++) begin
      send_val(8'(slice_v[i]));
      check($sformatf("slice_%0d", slice_v[i]), 32'(symbol_out), 32'(slice_e[i]));
    end
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Clean stream: 16 SEED + 32 HUNT symbols, locked two cycles after the 48th.
    nsent = 0;
    for (int i = 0; i < 48; i++) send_clean();
    check("lock_early", 32'(locked), 32'd0);
    send_clean();
    check("lock_rise", 32'(locked), 32'd1);
    check("lock_bits0", bit_count, 32'd0);
    for (int i = 0; i < 10; i++) send_clean();
    check("clean_bits", bit_count, 32'd20);
    check("clean_errs", err_count, 32'd0);

    // Single LSB error while locked.
    send_one_lsb_error("lsb_found");
    send_clean();
    check("lsb_errs", err_count, 32'd1);
    check("lsb_locked", 32'(locked), 32'd1);
    check("lsb_bits", bit_count, 32'(2 * (nsent - 49)));

    // clear_counters coincident with the checker seeing an error.
    send_one_lsb_error("clr_found");
    clear_counters = 1'b1;
    send_clean();
    clear_counters = 1'b0;
    check("clr_bits", bit_count, 32'd0);
    check("clr_errs", err_count, 32'd0);
    check("clr_locked", 32'(locked), 32'd1);
    send_clean();
    check("clr_bits_after", bit_count, 32'd2);
    check("clr_errs_after", err_count, 32'd0);

    // Reset in the middle of a locked run.
    rst = 1'b1;
    send_clean();
    rst = 1'b0;
    signal_in_valid = 1'b0;
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_bits", bit_count, 32'd0);
    check("midrst_valid", 32'(symbol_out_valid), 32'd0);

    // Lock timing with five idle cycles between valid symbols.
    for (int i = 1; i <= 48; i++) begin
      send_clean();
      if (i < 48) begin
        idle(5);
        if (i == 47) check("gap_valid_low", 32'(symbol_out_valid), 32'd0);
      end
    end
    check("gap_lock_early", 32'(locked), 32'd0);
    idle(1);
    check("gap_lock_rise", 32'(locked), 32'd1);
    idle(4);
    check("gap_bits_hold", bit_count, 32'd0);

    // Constant 0 V (symbol 11) while locked until the window error limit trips.
    cum = 0;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      gen_sym(sym);
      send_val(8'd0);
      e   = (sym[1] ? 0 : 1) + (sym[0] ? 0 : 1);
      cum = cum + e;
      if (cum > 64) hit = 1'b1;
    end
    check("garb_hit", 32'(hit), 32'd1);
    check("garb_hold", 32'(locked), 32'd1);
    check("garb_no_pulse", 32'(lock_lost), 32'd0);
    send_val(8'd0);
    check("garb_pulse", 32'(lock_lost), 32'd1);
    check("garb_unlocked", 32'(locked), 32'd0);
    check("garb_errs", err_count, 32'(cum));
    send_val(8'd0);
    check("garb_pulse_end", 32'(lock_lost), 32'd0);
    check("garb_errs_frozen", err_count, 32'(cum));
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
